// File: rtl/wb_host_master.sv
// wb_host_master: single-outstanding Wishbone initiator.
// Takes one command, runs one bus cycle with timeout, and returns one response.
`timescale 1ns/1ps
module wb_host_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        WB_CLK,
    input  logic        WB_RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [16:0] cmd_adr,
    input  logic [3:0]  cmd_byte_stb,
    input  logic [31:0] cmd_wdat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdat,
    output logic        rsp_err,
    output logic        busy,
    output logic [16:0] WBs_ADR,
    output logic        WBs_CYC,
    output logic [3:0]  WBs_BYTE_STB,
    output logic        WBs_WE,
    output logic        WBs_RD,
    output logic        WBs_STB,
    output logic [31:0] WBs_WR_DAT,
    input  logic [31:0] WBs_RD_DAT,
    input  logic        WBs_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last wait-count value; the cycle that sees it is the final bus cycle.
    localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [16:0] r_adr;
    logic [3:0]  r_bstb;
    logic        r_we;
    logic [31:0] r_wdat;
    logic [31:0] r_rdat;
    logic        r_err;
    logic [15:0] r_wait;
    logic        w_expire;

    assign w_expire     = (r_wait == LP_LAST);
    assign WBs_ADR      = r_adr;
    assign WBs_BYTE_STB = r_bstb;
    assign WBs_WR_DAT   = r_wdat;
    assign rsp_rdat     = r_rdat;
    assign rsp_err      = r_err;

    // State register.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs; ACK beats timeout in BUS.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        WBs_CYC   = 1'b0;
        WBs_STB   = 1'b0;
        WBs_WE    = 1'b0;
        WBs_RD    = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_next = BUS;
                end
            end
            BUS: begin
                WBs_CYC = 1'b1;
                WBs_STB = 1'b1;
                WBs_WE  = r_we;
                WBs_RD  = ~r_we;
                if (WBs_ACK || w_expire) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Command latch, wait counter and response capture.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            r_adr  <= '0;
            r_bstb <= '0;
            r_we   <= 1'b0;
            r_wdat <= '0;
            r_rdat <= '0;
            r_err  <= 1'b0;
            r_wait <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_adr  <= cmd_adr;
                        r_bstb <= cmd_byte_stb;
                        r_we   <= cmd_we;
                        r_wdat <= cmd_wdat;
                        r_wait <= '0;
                    end
                end
                BUS: begin
                    if (WBs_ACK) begin
                        r_rdat <= r_we ? 32'd0 : WBs_RD_DAT;
                        r_err  <= 1'b0;
                    end else if (w_expire) begin
                        r_rdat <= 32'd0;
                        r_err  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// tb_wb_host_master: randomized and directed checks of wb_host_master
// against a transaction-level model with a programmable-wait slave.
`timescale 1ns/1ps
module tb_wb_host_master;

    localparam int TO = 8;

    logic        WB_CLK = 1'b0;
    logic        WB_RST;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [16:0] cmd_adr;
    logic [3:0]  cmd_byte_stb;
    logic [31:0] cmd_wdat;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdat;
    logic [16:0] WBs_ADR;
    logic        WBs_CYC, WBs_WE, WBs_RD, WBs_STB, WBs_ACK;
    logic [3:0]  WBs_BYTE_STB;
    logic [31:0] WBs_WR_DAT, WBs_RD_DAT;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          slv_wait = 0;
    int          slv_cnt = 0;
    logic [31:0] slv_rdata = '0;
    logic        force_ack = 1'b0;

    wb_host_master #(.TIMEOUT_CYCLES(TO)) dut (
        .WB_CLK(WB_CLK), .WB_RST(WB_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_byte_stb(cmd_byte_stb), .cmd_wdat(cmd_wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdat(rsp_rdat),
        .rsp_err(rsp_err), .busy(busy),
        .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_BYTE_STB(WBs_BYTE_STB),
        .WBs_WE(WBs_WE), .WBs_RD(WBs_RD), .WBs_STB(WBs_STB),
        .WBs_WR_DAT(WBs_WR_DAT), .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK)
    );

    always #5 WB_CLK = ~WB_CLK;

    // Slave: acks in the (slv_wait+1)-th strobe cycle; force_ack drives ACK while idle.
    always @(posedge WB_CLK) slv_cnt <= WBs_STB ? slv_cnt + 1 : 0;
    assign WBs_ACK    = WBs_STB ? (slv_cnt == slv_wait) : force_ack;
    assign WBs_RD_DAT = slv_rdata;

    // Expected outcome of one transaction from the slave's wait count.
    function automatic void model(input logic we, input int wt, input logic [31:0] rd,
                                  output int e_stb, output logic e_err,
                                  output logic [31:0] e_rdat);
        e_err  = (wt + 1 > TO);
        e_stb  = e_err ? TO : wt + 1;
        e_rdat = (e_err || we) ? 32'd0 : rd;
    endfunction

    task automatic do_txn(input logic we, input logic [16:0] adr, input logic [3:0] bs,
                          input logic [31:0] wd, input int wt, input logic [31:0] rd,
                          input int hold, input bit hv,
                          output int stb_n, output int lat, output bit fbad,
                          output logic [31:0] rdat, output logic err,
                          output bit sbad, output logic post_v, output bit tmo);
        stb_n = 0; lat = 0; fbad = 0; sbad = 0; tmo = 0;
        slv_wait = wt; slv_rdata = rd;
        cmd_we = we; cmd_adr = adr; cmd_byte_stb = bs; cmd_wdat = wd;
        cmd_valid = 1'b1; rsp_ready = (hold == 0);
        if (cmd_ready !== 1'b1) fbad = 1;
        @(posedge WB_CLK); #1;
        lat = 1;
        if (!hv) cmd_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 60) begin
            if (WBs_STB === 1'b1) begin
                stb_n++;
                if (WBs_ADR !== adr || WBs_BYTE_STB !== bs || WBs_WR_DAT !== wd ||
                    WBs_WE !== we || WBs_RD !== ~we || WBs_CYC !== 1'b1 ||
                    busy !== 1'b1 || cmd_ready !== 1'b0) fbad = 1;
            end
            if (hv) begin
                cmd_adr = 17'($urandom); cmd_wdat = $urandom; cmd_we = ~we;
            end
            @(posedge WB_CLK); #1;
            lat++;
        end
        tmo = (lat >= 60);
        rdat = rsp_rdat; err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdat !== rdat || rsp_err !== err ||
                cmd_ready !== 1'b0 || WBs_CYC !== 1'b0) sbad = 1;
            if (hv) begin
                cmd_adr = 17'($urandom); cmd_wdat = $urandom;
            end
            @(posedge WB_CLK); #1;
        end
        rsp_ready = 1'b1;
        @(posedge WB_CLK); #1;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        post_v = rsp_valid;
    endtask

    task automatic test_reset();
        WB_RST = 1'b1;
        repeat (3) @(posedge WB_CLK);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_err, busy, WBs_CYC, WBs_STB, WBs_WE, WBs_RD} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b exp 0000000",
                     {rsp_valid, rsp_err, busy, WBs_CYC, WBs_STB, WBs_WE, WBs_RD});
        end
        n_cmp++;
        if ({WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT, rsp_rdat} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got adr=%h bs=%h wd=%h rd=%h exp 0",
                     WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT, rsp_rdat);
        end
        WB_RST = 1'b0;
        @(posedge WB_CLK); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int s, l; bit fb, sb, t; logic [31:0] r; logic e, pv;
        do_txn(1'b1, 17'h00010, 4'hF, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 0, 0,
               s, l, fb, r, e, sb, pv, t);
        n_cmp++;
        if (s !== 1 || fb) begin
            n_bad++;
            $display("FAIL write_stb got stb=%0d fbad=%0d exp stb=1 fbad=0", s, fb);
        end
        n_cmp++;
        if (l !== 2 || e !== 1'b0 || r !== 32'd0) begin
            n_bad++;
            $display("FAIL write_rsp got lat=%0d err=%b rd=%h exp lat=2 err=0 rd=0", l, e, r);
        end
        n_cmp++;
        if (pv !== 1'b0) begin
            n_bad++;
            $display("FAIL write_consume got rsp_valid=%b exp 0", pv);
        end
    endtask

    task automatic test_read_wait();
        int s, l; bit fb, sb, t; logic [31:0] r; logic e, pv;
        do_txn(1'b0, 17'h1_2340, 4'h3, 32'h0, 3, 32'h1234_5678, 0, 0,
               s, l, fb, r, e, sb, pv, t);
        n_cmp++;
        if (s !== 4 || fb) begin
            n_bad++;
            $display("FAIL read_stb got stb=%0d fbad=%0d exp stb=4 fbad=0", s, fb);
        end
        n_cmp++;
        if (r !== 32'h1234_5678 || e !== 1'b0 || l !== 5) begin
            n_bad++;
            $display("FAIL read_rsp got rd=%h err=%b lat=%0d exp rd=12345678 err=0 lat=5",
                     r, e, l);
        end
    endtask

    task automatic test_timeout();
        int s, l; bit fb, sb, t; logic [31:0] r; logic e, pv;
        force_ack = 1'b1;
        do_txn(1'b0, 17'h0_0F00, 4'hF, 32'h0, 100, 32'hFFFF_FFFF, 3, 0,
               s, l, fb, r, e, sb, pv, t);
        n_cmp++;
        if (s !== TO || fb) begin
            n_bad++;
            $display("FAIL timeout_stb got stb=%0d fbad=%0d exp stb=%0d", s, fb, TO);
        end
        n_cmp++;
        if (e !== 1'b1 || r !== 32'd0 || sb) begin
            n_bad++;
            $display("FAIL timeout_rsp got err=%b rd=%h sbad=%0d exp err=1 rd=0", e, r, sb);
        end
        repeat (2) @(posedge WB_CLK);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || WBs_CYC !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin
            n_bad++;
            $display("FAIL late_ack got busy=%b cyc=%b v=%b err=%b exp 0 0 0 1",
                     busy, WBs_CYC, rsp_valid, rsp_err);
        end
        force_ack = 1'b0;
    endtask

    task automatic test_ack_at_expiry();
        int s, l; bit fb, sb, t; logic [31:0] r; logic e, pv;
        do_txn(1'b0, 17'h0_0042, 4'h1, 32'h0, TO - 1, 32'hCAFE_F00D, 0, 0,
               s, l, fb, r, e, sb, pv, t);
        n_cmp++;
        if (s !== TO || e !== 1'b0 || r !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL ack_expiry got stb=%0d err=%b rd=%h exp stb=%0d err=0 rd=cafef00d",
                     s, e, r, TO);
        end
    endtask

    task automatic test_backpressure();
        int s, l; bit fb, sb, t; logic [31:0] r; logic e, pv;
        do_txn(1'b0, 17'h1_AAAA, 4'hC, 32'h0, 1, 32'h0BAD_CAFE, 5, 1,
               s, l, fb, r, e, sb, pv, t);
        n_cmp++;
        if (sb || fb || s !== 2) begin
            n_bad++;
            $display("FAIL backpressure got sbad=%0d fbad=%0d stb=%0d exp 0 0 2", sb, fb, s);
        end
        n_cmp++;
        if (r !== 32'h0BAD_CAFE || pv !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_rsp got rd=%h v=%b busy=%b exp 0badcafe 0 0", r, pv, busy);
        end
    endtask

    task automatic test_reset_bus();
        int s, l, seen; bit fb, sb, t; logic [31:0] r; logic e, pv;
        slv_wait = 100;
        cmd_we = 1'b1; cmd_adr = 17'h0_5555; cmd_byte_stb = 4'hF;
        cmd_wdat = 32'h7777_7777; cmd_valid = 1'b1;
        @(posedge WB_CLK); #1;
        cmd_valid = 1'b0;
        @(posedge WB_CLK); #1;
        WB_RST = 1'b1;
        @(posedge WB_CLK); #1;
        WB_RST = 1'b0;
        n_cmp++;
        if (WBs_CYC !== 1'b0 || WBs_STB !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_bus got cyc=%b stb=%b busy=%b exp 0 0 0", WBs_CYC, WBs_STB, busy);
        end
        seen = 0;
        repeat (12) begin
            if (rsp_valid === 1'b1 || WBs_CYC === 1'b1) seen++;
            @(posedge WB_CLK); #1;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL rst_bus_quiet got %0d active cycles exp 0", seen);
        end
        do_txn(1'b0, 17'h0_0123, 4'hF, 32'h0, 2, 32'h5A5A_A5A5, 0, 0,
               s, l, fb, r, e, sb, pv, t);
        n_cmp++;
        if (s !== 3 || fb || r !== 32'h5A5A_A5A5 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_bus_after got stb=%0d fbad=%0d rd=%h err=%b exp 3 0 5a5aa5a5 0",
                     s, fb, r, e);
        end
    endtask

    task automatic test_reset_resp();
        int n;
        slv_wait = 0; slv_rdata = 32'h1111_2222;
        cmd_we = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge WB_CLK); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge WB_CLK); #1;
            n++;
        end
        WB_RST = 1'b1;
        @(posedge WB_CLK); #1;
        WB_RST = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_rdat !== 32'd0 || cmd_ready !== 1'b1 || n >= 20) begin
            n_bad++;
            $display("FAIL rst_resp got v=%b rd=%h rdy=%b wait=%0d exp 0 0 1 <20",
                     rsp_valid, rsp_rdat, cmd_ready, n);
        end
    endtask

    task automatic test_back_to_back();
        int acc, rv;
        acc = 0; rv = 0;
        slv_wait = 0;
        cmd_we = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready === 1'b1) acc++;
            if (rsp_valid === 1'b1) rv++;
            @(posedge WB_CLK); #1;
        end
        cmd_valid = 1'b0;
        @(posedge WB_CLK); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if (acc !== 4 || rv !== 4) begin
            n_bad++;
            $display("FAIL back_to_back got acc=%0d rsp=%0d exp 4 4", acc, rv);
        end
    endtask

    task automatic test_random();
        int s, l, e_s; bit fb, sb, t; logic [31:0] r, e_r, rd, wd; logic e, pv, e_e, we;
        logic [16:0] adr; logic [3:0] bs; int wt, h;
        for (int k = 0; k < 24; k++) begin
            we = 1'($urandom); adr = 17'($urandom); bs = 4'($urandom);
            wd = $urandom; rd = $urandom;
            wt = $urandom_range(0, TO + 2); h = $urandom_range(0, 3);
            model(we, wt, rd, e_s, e_e, e_r);
            do_txn(we, adr, bs, wd, wt, rd, h, 1'($urandom), s, l, fb, r, e, sb, pv, t);
            n_cmp++;
            if (s !== e_s || l !== e_s + 1 || fb || t) begin
                n_bad++;
                $display("FAIL rand%0d_bus got stb=%0d lat=%0d fbad=%0d exp stb=%0d lat=%0d",
                         k, s, l, fb, e_s, e_s + 1);
            end
            n_cmp++;
            if (r !== e_r || e !== e_e || sb || pv !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d_rsp got rd=%h err=%b sbad=%0d v=%b exp rd=%h err=%b",
                         k, r, e, sb, pv, e_r, e_e);
            end
        end
    endtask

    initial begin
        WB_RST = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0;
        cmd_byte_stb = '0; cmd_wdat = '0; rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_ack_at_expiry();
        test_backpressure();
        test_reset_bus();
        test_reset_resp();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
